id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand selection for the 5-stage RV32I core.
//  Captures decoded fields from ID and forwards results from EX/MEM and MEM/WB.
//  Drives the ALU's rs1/rs2/alu_sel inputs directly and detects load-use hazards.
//  Sits between the decoder/register file and the ALU.
// PARAMETERS
//  XLEN   32  datapath width
//  RAW     5  register address width
// PORTS
//  clk            in   1     core clock, all state on rising edge
//  rst            in   1     synchronous, active-high reset
//  id_valid       in   1     ID holds a real instruction
//  id_rs1_data    in   XLEN  regfile read data, port 1
//  id_rs2_data    in   XLEN  regfile read data, port 2
//  id_imm         in   XLEN  sign-extended immediate
//  id_rs1_addr    in   RAW   source register 1 index
//  id_rs2_addr    in   RAW   source register 2 index
//  id_rd_addr     in   RAW   destination register index
//  id_alu_sel     in   4     ALU op: [3]=subtract; [2:0] 000 add, 110 or, 111 and
//  id_alu_src     in   1     1 = immediate is operand B
//  id_reg_write   in   1     instruction writes rd
//  id_mem_read    in   1     instruction is a load
//  hold           in   1     downstream memory stall: freeze register
//  flush          in   1     branch/jump redirect: kill ID instruction
//  exm_reg_write  in   1     EX/MEM stage writes rd
//  exm_rd_addr    in   RAW   EX/MEM destination register index
//  exm_result     in   XLEN  EX/MEM ALU result
//  wb_reg_write   in   1     MEM/WB stage writes rd
//  wb_rd_addr     in   RAW   MEM/WB destination register index
//  wb_result      in   XLEN  MEM/WB writeback value
//  alu_rs1        out  XLEN  ALU operand A, forwarded
//  alu_rs2        out  XLEN  ALU operand B, forwarded or immediate
//  alu_sel        out  4     registered id_alu_sel
//  ex_store_data  out  XLEN  forwarded rs2 for stores; never the immediate
//  ex_rd_addr     out  RAW   registered destination index
//  ex_reg_write   out  1     registered id_reg_write
//  ex_mem_read    out  1     registered id_mem_read
//  ex_valid       out  1     EX holds a real instruction
//  stall_req      out  1     load-use hazard; upstream must hold IF/ID
// BEHAVIOUR
//  - Register update priority on each clk edge:
//    rst > flush > hold > stall_req > load.
//  - rst, flush and stall_req all load a bubble: every registered field 0.
//    A bubble gives ex_valid=0, ex_reg_write=0, ex_mem_read=0 and alu_sel=4'b0000.
//  - hold keeps all registered fields unchanged.
//  - load captures all id_* inputs; latency ID->EX is 1 cycle.
//  - Forwarding is combinational (0 cycles) and applies per source (rs1 and rs2):
//    if src!=0 && exm_reg_write && exm_rd_addr==src, use exm_result;
//    else if src!=0 && wb_reg_write && wb_rd_addr==src, use wb_result;
//    else use the registered regfile data.
//  - EX/MEM always wins over MEM/WB. x0 is never forwarded.
//  - alu_rs2 = alu_src ? imm : fwd_rs2. ex_store_data = fwd_rs2.
//  - stall_req is combinational:
//    ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & (id_rs1_addr==ex_rd_addr | id_rs2_addr==ex_rd_addr).
//    It is conservative: rs2 is compared even when id_alu_src=1.
//  - stall_req is still driven while hold or flush is high. flush overrides it.
//  - After reset all addresses are 0, so no forwarding happens; alu_rs1=alu_rs2=0 and stall_req=0.
//  - Reset mid-stall: the bubble is loaded and stall_req drops the next cycle.
//  - No arithmetic here. All data is XLEN wide with no extension; the immediate arrives already extended.
// STRUCTURE
//  - Shared package/header riscv_pkg holds:
//    ALU op codes (ALU_ADD=3'b000, ALU_OR=3'b110, ALU_AND=3'b111, ALU_SUB_BIT=3);
//    forward-select encoding (FWD_REG=2'b00, FWD_EXM=2'b01, FWD_WB=2'b10);
//    XLEN and RAW.
//  - One sub-module, fwd_mux: compares and selects for one source operand.
//    It is instantiated twice, for rs1 and rs2. The register and stall logic stay in the top.
// TESTING
//  1. rst high 2 cycles -> ex_valid=0, alu_sel=4'b0000, alu_rs1=alu_rs2=0, stall_req=0.
//  2. ID rs1_data=5, rs2_data=7, alu_sel=4'b1000, valid, no forwarding
//     -> next cycle alu_rs1=5, alu_rs2=7, alu_sel=4'b1000, ex_valid=1.
//  3. EX rs1=x3; exm rd=3 result 0xAA, wb rd=3 result 0xBB -> alu_rs1=0xAA.
//     Then exm_reg_write=0 -> 0xBB. Then rs1=x0 with rd=0 matches -> registered data.
//  4. EX holds load to x5, ID instruction reads x5 -> stall_req=1.
//     Next cycle ex_valid=0 (bubble) and stall_req=0. Retried instruction loads one cycle later.
//  5. hold for 3 cycles -> all outputs constant. Then flush+hold together -> bubble loaded.
//  6. imm=32'hFFFFFFFC, alu_src=1, rs2 forwarded 0x10 from WB
//     -> alu_rs2=32'hFFFFFFFC, ex_store_data=0x10.

Source files
------------

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the RV32I core datapath.
//   Contents:
//     XLEN, RAW      datapath width and register address width
//     ALU_*          ALU op codes carried in alu_sel[2:0]
//     ALU_SUB_BIT    bit of alu_sel that turns add into subtract
//     fwd_sel_e      operand source selected by the forwarding mux
//     id_ex_t        the fields held in the ID/EX pipeline register
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_OR      = 3'b110;
    localparam logic [2:0] ALU_AND     = 3'b111;
    localparam int         ALU_SUB_BIT = 3;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,  // registered regfile data
        FWD_EXM = 2'b01,  // EX/MEM ALU result
        FWD_WB  = 2'b10   // MEM/WB writeback value
    } fwd_sel_e;

    // ID/EX register contents. An all-zero value is a bubble: valid,
    // reg_write and mem_read are 0 and every address is x0, so a bubble can
    // neither forward, write back nor raise a load-use stall.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RAW-1:0]  rs1_addr;
        logic [RAW-1:0]  rs2_addr;
        logic [RAW-1:0]  rd_addr;
        logic [3:0]      alu_sel;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
    } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// ----------------------------------------------------------------------------
// fwd_mux
//   Forwarding compare-and-select for one EX source operand.
//   Ports:
//     src_addr       in   RAW   source register index held in ID/EX
//     reg_data       in   XLEN  regfile data captured in ID/EX
//     exm_reg_write  in   1     EX/MEM stage writes rd
//     exm_rd_addr    in   RAW   EX/MEM destination index
//     exm_result     in   XLEN  EX/MEM ALU result
//     wb_reg_write   in   1     MEM/WB stage writes rd
//     wb_rd_addr     in   RAW   MEM/WB destination index
//     wb_result      in   XLEN  MEM/WB writeback value
//     fwd_data       out  XLEN  operand after forwarding
//   Purely combinational. EX/MEM is younger than MEM/WB, so it is checked
//   first. x0 is hard-wired zero and is never forwarded.
// ----------------------------------------------------------------------------
module fwd_mux
    import riscv_pkg::*;
(
    input  logic [RAW-1:0]  src_addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            exm_reg_write,
    input  logic [RAW-1:0]  exm_rd_addr,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_reg_write,
    input  logic [RAW-1:0]  wb_rd_addr,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] fwd_data
);

    fwd_sel_e sel;
    logic     src_nonzero;

    assign src_nonzero = (src_addr != '0);

    always_comb begin
        sel = FWD_REG;
        if (src_nonzero && exm_reg_write && (exm_rd_addr == src_addr)) begin
            sel = FWD_EXM;
        end else if (src_nonzero && wb_reg_write && (wb_rd_addr == src_addr)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        fwd_data = reg_data;
        case (sel)
            FWD_EXM: fwd_data = exm_result;
            FWD_WB:  fwd_data = wb_result;
            default: fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register plus EX-stage operand selection for the 5-stage
//   RV32I core. Sits between the decoder/register file and the ALU.
//   Ports (widths from riscv_pkg: XLEN=32, RAW=5):
//     clk, rst                  clock; synchronous active-high reset
//     id_*                      decoded instruction fields from ID
//     hold                      memory stall: freeze the register
//     flush                     redirect: kill the instruction in ID
//     exm_*, wb_*               EX/MEM and MEM/WB writeback info for forwarding
//     alu_rs1, alu_rs2, alu_sel ALU inputs (forwarded / immediate)
//     ex_store_data             forwarded rs2 for stores
//     ex_rd_addr, ex_reg_write, ex_mem_read, ex_valid   registered controls
//     stall_req                 load-use hazard, upstream must hold IF/ID
//
//   Valid/stall semantics: id_valid qualifies the ID instruction and ex_valid
//   the EX instruction; there is no ready signal. When stall_req is high the
//   ID instruction is not consumed: a bubble enters EX and the upstream stage
//   must present the same instruction again on the next cycle.
//
//   Register update priority per clock edge: rst > flush > hold > stall > load.
// ----------------------------------------------------------------------------
module id_ex_operand_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_rs1_data,
    input  logic [31:0]     id_rs2_data,
    input  logic [31:0]     id_imm,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic [3:0]      id_alu_sel,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            hold,
    input  logic            flush,
    input  logic            exm_reg_write,
    input  logic [4:0]      exm_rd_addr,
    input  logic [31:0]     exm_result,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd_addr,
    input  logic [31:0]     wb_result,
    output logic [31:0]     alu_rs1,
    output logic [31:0]     alu_rs2,
    output logic [3:0]      alu_sel,
    output logic [31:0]     ex_store_data,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_valid,
    output logic            stall_req
);

    id_ex_t          id_fields;
    id_ex_t          ex_q;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            rd_hit;

    // Bundle the ID inputs so the register load is a single assignment.
    always_comb begin
        id_fields           = '0;
        id_fields.valid     = id_valid;
        id_fields.rs1_data  = id_rs1_data;
        id_fields.rs2_data  = id_rs2_data;
        id_fields.imm       = id_imm;
        id_fields.rs1_addr  = id_rs1_addr;
        id_fields.rs2_addr  = id_rs2_addr;
        id_fields.rd_addr   = id_rd_addr;
        id_fields.alu_sel   = id_alu_sel;
        id_fields.alu_src   = id_alu_src;
        id_fields.reg_write = id_reg_write;
        id_fields.mem_read  = id_mem_read;
    end

    // hold outranks stall_req: while memory is stalled nothing moves, and the
    // hazard is still pending when hold drops, so the bubble goes in then.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_q <= '0;
        end else if (hold) begin
            ex_q <= ex_q;
        end else if (stall_req) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_fields;
        end
    end

    // Load-use hazard. rs2 is compared even for immediate-form instructions;
    // an occasional needless stall is cheaper than decoding operand usage.
    assign rd_hit    = (id_rs1_addr == ex_q.rd_addr) || (id_rs2_addr == ex_q.rd_addr);
    assign stall_req = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0)
                       && id_valid && rd_hit;

    fwd_mux u_fwd_rs1 (
        .src_addr      (ex_q.rs1_addr),
        .reg_data      (ex_q.rs1_data),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .fwd_data      (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .src_addr      (ex_q.rs2_addr),
        .reg_data      (ex_q.rs2_data),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .fwd_data      (fwd_rs2)
    );

    // Stores always take the register value of rs2, even though operand B of
    // the ALU carries the immediate (address offset) for them.
    assign alu_rs1       = fwd_rs1;
    assign alu_rs2       = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_sel       = ex_q.alu_sel;
    assign ex_rd_addr    = ex_q.rd_addr;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_valid      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_operand_stage
//   Directed bench for id_ex_operand_stage. Inputs change 1 ns after each
//   rising edge; the expected outputs for that cycle are queued at the same
//   time and a monitor checks them on the falling edge.
// ----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_sel;
    logic        id_alu_src, id_reg_write, id_mem_read;
    logic        hold, flush;
    logic        exm_reg_write;
    logic [4:0]  exm_rd_addr;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_result;
    logic [31:0] alu_rs1, alu_rs2, ex_store_data;
    logic [3:0]  alu_sel;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write, ex_mem_read, ex_valid, stall_req;

    id_ex_operand_stage dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rd_addr    (id_rd_addr),
        .id_alu_sel    (id_alu_sel),
        .id_alu_src    (id_alu_src),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .hold          (hold),
        .flush         (flush),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .alu_rs1       (alu_rs1),
        .alu_rs2       (alu_rs2),
        .alu_sel       (alu_sel),
        .ex_store_data (ex_store_data),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_valid      (ex_valid),
        .stall_req     (stall_req)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] store;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        valid;
        logic        stall;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    errors;

    task automatic chk(input string step, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", step, field, act, exp);
        end
    endtask

    // Monitor: one queued expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            chk(n, "alu_rs1",       alu_rs1,              e.rs1);
            chk(n, "alu_rs2",       alu_rs2,              e.rs2);
            chk(n, "ex_store_data", ex_store_data,        e.store);
            chk(n, "alu_sel",       32'(alu_sel),         32'(e.sel));
            chk(n, "ex_rd_addr",    32'(ex_rd_addr),      32'(e.rd));
            chk(n, "ex_reg_write",  32'(ex_reg_write),    32'(e.rw));
            chk(n, "ex_mem_read",   32'(ex_mem_read),     32'(e.mr));
            chk(n, "ex_valid",      32'(ex_valid),        32'(e.valid));
            chk(n, "stall_req",     32'(stall_req),       32'(e.stall));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] r1d, input logic [31:0] r2d,
                          input logic [31:0] imm, input logic [4:0] r1a, input logic [4:0] r2a,
                          input logic [4:0] rd, input logic [3:0] sel, input logic src,
                          input logic rw, input logic mr);
        id_valid     = v;
        id_rs1_data  = r1d;
        id_rs2_data  = r2d;
        id_imm       = imm;
        id_rs1_addr  = r1a;
        id_rs2_addr  = r2a;
        id_rd_addr   = rd;
        id_alu_sel   = sel;
        id_alu_src   = src;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic set_idle();
        set_id(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Dependent instruction: reads x5 (rs1) and x2 (rs2), writes x7.
    task automatic set_dep();
        set_id(1'b1, 32'h55, 32'h66, 32'h0, 5'd5, 5'd2, 5'd7, 4'b0111, 1'b0, 1'b1, 1'b0);
    endtask

    // Load to x5 from x0 + 8.
    task automatic set_load2();
        set_id(1'b1, 32'h0, 32'h0, 32'h8, 5'd0, 5'd0, 5'd5, 4'b0000, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
        exm_reg_write = ew;
        exm_rd_addr   = erd;
        exm_result    = eres;
        wb_reg_write  = ww;
        wb_rd_addr    = wrd;
        wb_result     = wres;
    endtask

    task automatic expect_out(input string n, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] store, input logic [3:0] sel,
                              input logic [4:0] rd, input logic rw, input logic mr,
                              input logic v, input logic st);
        exp_t e;
        e.rs1   = rs1;
        e.rs2   = rs2;
        e.store = store;
        e.sel   = sel;
        e.rd    = rd;
        e.rw    = rw;
        e.mr    = mr;
        e.valid = v;
        e.stall = st;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic expect_bubble(input string n);
        expect_out(n, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        hold   = 1'b0;
        flush  = 1'b0;
        set_idle();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset held for two edges.
        next_cycle();
        expect_bubble("reset0");
        next_cycle();
        rst = 1'b0;
        set_id(1'b1, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd4, 4'b1000, 1'b0, 1'b1, 1'b0);
        expect_bubble("reset1");

        // Plain load, no forwarding; next instruction reads x3.
        next_cycle();
        set_id(1'b1, 32'h11, 32'h22, 32'h0, 5'd3, 5'd0, 5'd6, 4'b0110, 1'b0, 1'b1, 1'b0);
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        expect_out("basic", 32'h5, 32'h7, 32'h7, 4'b1000, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);

        // EX/MEM beats MEM/WB, then MEM/WB alone (x3 held in EX).
        next_cycle();
        hold = 1'b1;
        expect_out("fwd_exm", 32'hAA, 32'h22, 32'h22, 4'b0110, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        set_fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        expect_out("fwd_wb", 32'hBB, 32'h22, 32'h22, 4'b0110, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);

        // Writers target x0: x3 no longer matches.
        next_cycle();
        hold = 1'b0;
        set_id(1'b1, 32'h33, 32'h44, 32'h0, 5'd0, 5'd0, 5'd1, 4'b0111, 1'b0, 1'b1, 1'b0);
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        expect_out("fwd_none", 32'h11, 32'h22, 32'h22, 4'b0110, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);

        // EX sources are x0 and both writers target x0: never forwarded.
        next_cycle();
        set_id(1'b1, 32'h100, 32'h0, 32'h4, 5'd1, 5'd0, 5'd5, 4'b0000, 1'b1, 1'b1, 1'b1);
        expect_out("fwd_x0", 32'h33, 32'h44, 32'h44, 4'b0111, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Load to x5 in EX, ID reads x5 -> stall, bubble, retry.
        next_cycle();
        set_dep();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_out("load_use", 32'h100, 32'h4, 32'h0, 4'b0000, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        next_cycle();
        expect_bubble("stall_bubble");

        // Retried instruction in EX; hold 3 cycles with a different ID.
        next_cycle();
        hold = 1'b1;
        set_id(1'b1, 32'h99, 32'h98, 32'h0, 5'd9, 5'd10, 5'd11, 4'b0110, 1'b0, 1'b1, 1'b1);
        expect_out("retry", 32'h55, 32'h66, 32'h66, 4'b0111, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        expect_out("hold1", 32'h55, 32'h66, 32'h66, 4'b0111, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        expect_out("hold2", 32'h55, 32'h66, 32'h66, 4'b0111, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        flush = 1'b1;
        expect_out("hold3", 32'h55, 32'h66, 32'h66, 4'b0111, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        hold  = 1'b0;
        flush = 1'b0;
        set_idle();
        expect_bubble("hold_flush");

        // Immediate operand B, store data forwarded from MEM/WB.
        next_cycle();
        set_id(1'b1, 32'h1, 32'h77, 32'hFFFF_FFFC, 5'd1, 5'd8, 5'd9, 4'b0000, 1'b1, 1'b1, 1'b0);
        expect_bubble("idle");
        next_cycle();
        set_idle();
        set_fwd(1'b1, 5'd9, 32'hDEAD, 1'b1, 5'd8, 32'h10);
        expect_out("imm_store", 32'h1, 32'hFFFF_FFFC, 32'h10, 4'b0000, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);

        // flush overrides a pending stall.
        next_cycle();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_load2();
        expect_bubble("idle2");
        next_cycle();
        set_dep();
        flush = 1'b1;
        expect_out("flush_stall", 32'h0, 32'h8, 32'h0, 4'b0000, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        next_cycle();
        flush = 1'b0;
        expect_bubble("flush_bubble");

        // hold during a stall keeps the load; then reset mid-stall.
        next_cycle();
        set_load2();
        expect_out("retry2", 32'h55, 32'h66, 32'h66, 4'b0111, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        set_dep();
        hold = 1'b1;
        expect_out("hold_stall", 32'h0, 32'h8, 32'h0, 4'b0000, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        next_cycle();
        hold = 1'b0;
        rst  = 1'b1;
        expect_out("rst_stall", 32'h0, 32'h8, 32'h0, 4'b0000, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        next_cycle();
        rst = 1'b0;
        set_idle();
        expect_bubble("rst_bubble");

        // Let the monitor drain, with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
